// File: rtl/jc2_pkg.sv
// Shared state codes, drive payload and widths for the jc2 counter and its direction controller.
package jc2_pkg;

  localparam logic [1:0] ST_STALL = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  localparam int unsigned DIR_W  = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned TICK_W = 24;
  localparam int unsigned DEB_W  = 16;

  typedef enum logic [1:0] {
    S_STALL = ST_STALL,
    S_LEFT  = ST_LEFT,
    S_RIGHT = ST_RIGHT
  } state_t;

  // Active-low command lines toward the counter.
  typedef struct packed {
    logic stop_n;
    logic go_left_n;
    logic go_right_n;
  } drive_t;

  function automatic drive_t drive_of(input state_t s);
    drive_t d;
    case (s)
      S_LEFT:  d = '{stop_n: 1'b1, go_left_n: 1'b0, go_right_n: 1'b1};
      S_RIGHT: d = '{stop_n: 1'b1, go_left_n: 1'b1, go_right_n: 1'b0};
      default: d = '{stop_n: 1'b0, go_left_n: 1'b1, go_right_n: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/jc2_dir_ctrl_if.sv
// Board-side buttons/mode in, counter-side command lines and status out.
interface jc2_dir_ctrl_if;
  import jc2_pkg::*;

  logic             btn_left_n;
  logic             btn_right_n;
  logic             btn_stop_n;
  logic             auto_en;
  logic             go_left_n;
  logic             go_right_n;
  logic             stop_n;
  logic             step;
  logic [DIR_W-1:0] dir;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    output btn_left_n, btn_right_n, btn_stop_n, auto_en,
    input  go_left_n, go_right_n, stop_n, step, dir, step_cnt
  );

  modport slave (
    input  btn_left_n, btn_right_n, btn_stop_n, auto_en,
    output go_left_n, go_right_n, stop_n, step, dir, step_cnt
  );

endinterface

// File: rtl/jc2_debounce.sv
// Button conditioner: 2-FF synchronizer, stability filter, one-cycle pulse on filtered press.
module jc2_debounce
  import jc2_pkg::*;
#(
  parameter logic [DEB_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [DEB_W-1:0] cnt;

  // level only follows sync2 after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn_n;
      sync2   <= sync1;
      level_d <= level;
      press   <= level_d & ~level;
      if (sync2 != level) begin
        if (cnt == DEBOUNCE_CYCLES - DEB_W'(1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + DEB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/jc2_dir_ctrl.sv
// Direction/rate controller for the jc2 Johnson counter: button FSM, step prescaler,
// per-leg step counter and optional auto-sweep reversal.
module jc2_dir_ctrl
  import jc2_pkg::*;
#(
  parameter logic [DEB_W-1:0]  DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [TICK_W-1:0] TICK_DIV        = 24'd5000000,
  parameter logic [CNT_W-1:0]  SWEEP_STEPS     = 8'd8
) (
  input logic           clk,
  input logic           rst_n,
  jc2_dir_ctrl_if.slave bus
);

  logic press_left;
  logic press_right;
  logic press_stop;

  jc2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_left_n), .press(press_left)
  );
  jc2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_right_n), .press(press_right)
  );
  jc2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_stop (
    .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_stop_n), .press(press_stop)
  );

  state_t              state_q, state_nxt;
  logic [TICK_W-1:0]   presc_q, presc_nxt;
  logic                step_q, step_nxt;
  logic [CNT_W-1:0]    step_cnt_q, step_cnt_nxt;
  drive_t              drive_q, drive_nxt;

  logic moving;
  logic wrap;
  logic leg_end;
  logic restart;

  assign moving  = (state_q != S_STALL);
  assign wrap    = moving && (presc_q == TICK_DIV - TICK_W'(1));
  // The step just registered closed the leg; buttons still override the new direction.
  assign leg_end = bus.auto_en && moving && step_q && (step_cnt_q >= SWEEP_STEPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_STALL;
      presc_q    <= '0;
      step_q     <= 1'b0;
      step_cnt_q <= '0;
      drive_q    <= drive_of(S_STALL);
    end else begin
      state_q    <= state_nxt;
      presc_q    <= presc_nxt;
      step_q     <= step_nxt;
      step_cnt_q <= step_cnt_nxt;
      drive_q    <= drive_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    presc_nxt    = presc_q;
    step_nxt     = 1'b0;
    step_cnt_nxt = step_cnt_q;
    restart      = 1'b0;

    if (press_stop) begin
      state_nxt = S_STALL;
    end else if (press_left) begin
      state_nxt = S_LEFT;
    end else if (press_right) begin
      state_nxt = S_RIGHT;
    end else if (leg_end) begin
      state_nxt = (state_q == S_LEFT) ? S_RIGHT : S_LEFT;
    end

    restart = (state_nxt != state_q) || leg_end;

    if (!moving || restart) begin
      presc_nxt = '0;
    end else if (wrap) begin
      presc_nxt = '0;
    end else begin
      presc_nxt = presc_q + TICK_W'(1);
    end

    step_nxt = wrap && !restart;

    if (restart || state_nxt == S_STALL) begin
      step_cnt_nxt = '0;
    end else if (wrap && step_cnt_q != '1) begin
      step_cnt_nxt = step_cnt_q + CNT_W'(1);
    end

    drive_nxt = drive_of(state_nxt);
  end

  assign bus.dir        = state_q;
  assign bus.step       = step_q;
  assign bus.step_cnt   = step_cnt_q;
  assign bus.stop_n     = drive_q.stop_n;
  assign bus.go_left_n  = drive_q.go_left_n;
  assign bus.go_right_n = drive_q.go_right_n;

endmodule

// File: tb/tb_jc2_dir_ctrl.sv
// Directed bench for jc2_dir_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=3, SWEEP_STEPS=4.
module tb_jc2_dir_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  jc2_dir_ctrl_if bus ();

  jc2_dir_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .TICK_DIV       (24'd3),
    .SWEEP_STEPS    (8'd4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] d, input logic [7:0] cnt, input logic stp);
    logic [2:0] drv;
    case (d)
      2'd1:    drv = 3'b101;
      2'd2:    drv = 3'b110;
      default: drv = 3'b011;
    endcase
    check({tag, ".dir"}, 32'(bus.dir), 32'(d));
    check({tag, ".drive"}, 32'({bus.stop_n, bus.go_left_n, bus.go_right_n}), 32'(drv));
    check({tag, ".cnt"}, 32'(bus.step_cnt), 32'(cnt));
    check({tag, ".step"}, 32'(bus.step), 32'(stp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen_step;
    logic [1:0] exp_dir;

    bus.btn_left_n  = 1'b1;
    bus.btn_right_n = 1'b1;
    bus.btn_stop_n  = 1'b1;
    bus.auto_en     = 1'b0;

    // 1. reset and idle
    #2 rst_n = 1'b0;
    #1;
    check_outs("reset", 2'd0, 8'd0, 1'b0);
    tick(3);
    rst_n = 1'b1;
    seen_step = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen_step |= bus.step;
    end
    check("idle_no_step", 32'(seen_step), 32'd0);
    check_outs("idle", 2'd0, 8'd0, 1'b0);

    // 2. bounce rejected, then a real press
    bus.btn_left_n = 1'b0;
    tick(3);
    bus.btn_left_n = 1'b1;
    tick(12);
    check_outs("bounce", 2'd0, 8'd0, 1'b0);

    bus.btn_left_n = 1'b0;
    tick(7);
    check("left_before", 32'(bus.go_left_n), 32'd1);
    tick(1);
    check_outs("left_enter", 2'd1, 8'd0, 1'b0);
    tick(2);
    bus.btn_left_n = 1'b1;
    check("left_presc2", 32'(bus.step), 32'd0);
    tick(1);
    check_outs("left_step1", 2'd1, 8'd1, 1'b1);
    tick(1);
    check_outs("left_after1", 2'd1, 8'd1, 1'b0);
    tick(2);
    check_outs("left_step2", 2'd1, 8'd2, 1'b1);
    tick(3);
    check_outs("left_step3", 2'd1, 8'd3, 1'b1);

    // 3. stop and right together: stop wins
    bus.btn_stop_n  = 1'b0;
    bus.btn_right_n = 1'b0;
    tick(7);
    check_outs("stop_before", 2'd1, 8'd5, 1'b0);
    tick(1);
    check_outs("stop_enter", 2'd0, 8'd0, 1'b0);
    tick(2);
    bus.btn_stop_n  = 1'b1;
    bus.btn_right_n = 1'b1;
    seen_step = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen_step |= bus.step;
    end
    check("stall_no_step", 32'(seen_step), 32'd0);
    check_outs("stall_hold", 2'd0, 8'd0, 1'b0);

    // 4. auto-sweep: STALL stays put, then three full legs from RIGHT
    bus.auto_en = 1'b1;
    tick(5);
    check_outs("auto_stall", 2'd0, 8'd0, 1'b0);
    bus.btn_right_n = 1'b0;
    tick(8);
    check_outs("auto_right", 2'd2, 8'd0, 1'b0);
    tick(2);
    bus.btn_right_n = 1'b1;
    tick(10);
    exp_dir = 2'd2;
    for (int leg = 0; leg < 3; leg++) begin
      check_outs("leg_end", exp_dir, 8'd4, 1'b1);
      exp_dir = (exp_dir == 2'd2) ? 2'd1 : 2'd2;
      tick(1);
      check_outs("leg_rev", exp_dir, 8'd0, 1'b0);
      tick(12);
    end
    // now at the end of the fourth leg (LEFT, 4 steps)
    check_outs("leg4_end", 2'd1, 8'd4, 1'b1);
    tick(1);
    check_outs("leg4_rev", 2'd2, 8'd0, 1'b0);

    // 5. right press pulse on the reversal cycle keeps RIGHT
    tick(5);
    bus.btn_right_n = 1'b0;
    tick(7);
    check_outs("coinc_pre", 2'd2, 8'd4, 1'b1);
    tick(1);
    check_outs("coinc_win", 2'd2, 8'd0, 1'b0);
    bus.btn_right_n = 1'b1;
    tick(3);
    check_outs("coinc_step", 2'd2, 8'd1, 1'b1);

    // drop auto_en mid-leg: keep direction, count past SWEEP_STEPS
    bus.auto_en = 1'b0;
    tick(12);
    check_outs("noauto_cnt5", 2'd2, 8'd5, 1'b1);

    // 6. async reset mid-prescale in LEFT
    bus.btn_left_n = 1'b0;
    tick(8);
    check_outs("rst_left", 2'd1, 8'd0, 1'b0);
    bus.btn_left_n = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #1;
    check_outs("rst_async", 2'd0, 8'd0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    seen_step = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen_step |= bus.step;
    end
    check("post_rst_no_step", 32'(seen_step), 32'd0);
    check_outs("post_rst", 2'd0, 8'd0, 1'b0);

    bus.btn_left_n = 1'b0;
    tick(8);
    check_outs("repress", 2'd1, 8'd0, 1'b0);
    bus.btn_left_n = 1'b1;
    tick(3);
    check_outs("repress_step", 2'd1, 8'd1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
